// File: rtl/bus_rx_pkg.sv
// Shared widths and FSM state type for the external read-data receiver.
package bus_rx_pkg;

    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACKED = 2'd1,
        STALL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/bus_rx_fifo.sv
// Word FIFO between the half-word assembler and the core; push while full
// is only accepted together with a pop.
module bus_rx_fifo #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] pop_data,
    output logic              valid,
    output logic              full
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              wr_en;
    logic              rd_en;

    assign valid    = (count != '0);
    assign full     = (count == FULL_CNT);
    assign rd_en    = pop && valid;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hio18_gf28slp_iopad.sv
// Behavioural stand-in for the 1.8 V bidirectional IO pad library cell.
module HIO18_GF28SLP_IOPAD (
    input  logic A,
    input  logic OE,
    input  logic IE,
    input  logic OE18,
    input  logic PAD_I,
    output logic PAD_O,
    output logic Y
);

    // OE18 only selects the driver supply rail, so it has no logical effect here.
    logic unused_oe18;
    assign unused_oe18 = OE18;

    assign PAD_O = OE ? A : 1'b0;
    assign Y     = IE ? PAD_I : 1'b0;

endmodule

// File: rtl/bus_rdata_rx.sv
// External 4-phase read-data receiver: pads, strobe synchronizer, handshake
// FSM and half-word assembly into 32-bit words for the core.
module bus_rdata_rx
    import bus_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              oe18_tie,
    input  logic [HALF_W-1:0] I_BUS_DATA,
    input  logic              I_BUS_STB,
    output logic              O_BUS_ACK,
    output logic [WORD_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    input  logic              rdata_ready_i,
    input  logic              flush_i,
    output logic              busy_o
);

    logic [HALF_W-1:0] pad_data;
    logic [HALF_W-1:0] unused_data_pad_out;
    logic              pad_stb;
    logic              unused_stb_pad_out;
    logic              unused_ack_pad_in;
    logic              ack;

    for (genvar i = 0; i < HALF_W; i++) begin : g_data_pad
        HIO18_GF28SLP_IOPAD u_pad (
            .A     (1'b0),
            .OE    (1'b0),
            .IE    (1'b1),
            .OE18  (oe18_tie),
            .PAD_I (I_BUS_DATA[i]),
            .PAD_O (unused_data_pad_out[i]),
            .Y     (pad_data[i])
        );
    end

    HIO18_GF28SLP_IOPAD u_stb_pad (
        .A     (1'b0),
        .OE    (1'b0),
        .IE    (1'b1),
        .OE18  (oe18_tie),
        .PAD_I (I_BUS_STB),
        .PAD_O (unused_stb_pad_out),
        .Y     (pad_stb)
    );

    HIO18_GF28SLP_IOPAD u_ack_pad (
        .A     (ack),
        .OE    (1'b1),
        .IE    (1'b0),
        .OE18  (oe18_tie),
        .PAD_I (1'b0),
        .PAD_O (O_BUS_ACK),
        .Y     (unused_ack_pad_in)
    );

    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] primed;
    logic                   stb_s;
    logic                   armed;

    assign stb_s = sync[SYNC_STAGES-1];

    // primed marks when stb_s reflects post-reset samples; armed then needs
    // one low strobe so a strobe left high across reset is never recaptured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            primed <= '0;
            armed  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], pad_stb};
            primed <= {primed[SYNC_STAGES-2:0], 1'b1};
            if (primed[SYNC_STAGES-1] && !stb_s) begin
                armed <= 1'b1;
            end
        end
    end

    rx_state_e         state;
    rx_state_e         state_d;
    logic              capture;
    logic              half_ptr;
    logic [HALF_W-1:0] lo;
    logic              push;
    logic              push_ok;
    logic              fifo_full;
    logic              pop;

    assign pop     = rdata_valid_o && rdata_ready_i;
    assign push_ok = !half_ptr || !fifo_full || pop;
    assign push    = capture && half_ptr && !flush_i;
    assign ack     = (state == ACKED);
    assign busy_o  = (state != IDLE) || half_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (stb_s && armed) begin
                    if (push_ok) begin
                        capture = 1'b1;
                        state_d = ACKED;
                    end else begin
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                if (!stb_s) begin
                    state_d = IDLE;
                end else if (push_ok) begin
                    capture = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (!stb_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_ptr <= 1'b0;
            lo       <= '0;
        end else if (flush_i) begin
            half_ptr <= 1'b0;
        end else if (capture) begin
            if (!half_ptr) begin
                lo       <= pad_data;
                half_ptr <= 1'b1;
            end else begin
                half_ptr <= 1'b0;
            end
        end
    end

    bus_rx_fifo #(
        .WORD_W     (WORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_i),
        .push      (push),
        .push_data ({pad_data, lo}),
        .pop       (pop),
        .pop_data  (rdata_o),
        .valid     (rdata_valid_o),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_bus_rdata_rx.sv
// Randomised handshake bench for bus_rdata_rx with a queue-based word model.
module tb_bus_rdata_rx;

    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        oe18_tie;
    logic [15:0] bus_data;
    logic        stb;
    logic        ack;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic        flush;
    logic        busy;

    always #5 clk = ~clk;

    bus_rdata_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .oe18_tie      (oe18_tie),
        .I_BUS_DATA    (bus_data),
        .I_BUS_STB     (stb),
        .O_BUS_ACK     (ack),
        .rdata_o       (rdata),
        .rdata_valid_o (valid),
        .rdata_ready_i (ready),
        .flush_i       (flush),
        .busy_o        (busy)
    );

    int checks = 0;
    int errors = 0;
    int ack_rises = 0;
    int valid_cycles = 0;
    logic [31:0] last_pop = '0;
    bit rand_ready = 1'b0;

    // Reference model: every acknowledged half-word is one accepted transfer;
    // pairs form words (first half low), words leave in order on valid&ready.
    logic [31:0] exp_q[$];
    logic        have_lo = 1'b0;
    logic [15:0] lo_half = '0;
    logic        ack_q = 1'b0;
    logic        flush_q = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                have_lo = 1'b0;
                ack_q   = 1'b0;
                flush_q = 1'b0;
            end else begin
                if (ack && !ack_q) ack_rises++;
                if (flush_q) begin
                    exp_q.delete();
                    have_lo = 1'b0;
                end else if (ack && !ack_q) begin
                    if (have_lo) begin
                        exp_q.push_back({bus_data, lo_half});
                        have_lo = 1'b0;
                    end else begin
                        lo_half = bus_data;
                        have_lo = 1'b1;
                    end
                end
                ack_q   = ack;
                flush_q = flush;
                checks++;
                if (valid !== (exp_q.size() != 0)) begin
                    errors++;
                    $display("FAIL model_valid got %b want %b at %0t", valid, exp_q.size() != 0, $time);
                end
                if (valid === 1'b1) begin
                    valid_cycles++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL model_data got %h want <none> at %0t", rdata, $time);
                    end else if (rdata !== exp_q[0]) begin
                        errors++;
                        $display("FAIL model_data got %h want %h at %0t", rdata, exp_q[0], $time);
                    end
                    if (ready && !flush && exp_q.size() != 0) begin
                        last_pop = rdata;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_half(input logic [15:0] d, output int lat);
        int n;
        bus_data = d;
        stb = 1'b1;
        lat = 0;
        while (ack !== 1'b1 && lat < 200) begin
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            tick(1);
            lat++;
        end
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL hs_ack_rise got ack=%b want 1 after %0d cycles", ack, lat);
        end
        stb = 1'b0;
        n = 0;
        while (ack !== 1'b0 && n < 200) begin
            if (rand_ready) ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL hs_ack_fall got ack=%b want 0 after %0d cycles", ack, n);
        end
        tick(1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        tick(1);
        checks++;
        if (exp_q.size() != 0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL drain got valid=%b left=%0d want valid=0 left=0", valid, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({ack, valid, busy} !== 3'b000 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b valid=%b busy=%b rdata=%h want 0 0 0 0", ack, valid, busy, rdata);
        end
        rst_n = 1'b1;
        tick(5);
        checks++;
        if ({ack, valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got ack=%b valid=%b busy=%b want 0 0 0", ack, valid, busy);
        end
    endtask

    task automatic test_basic;
        int a0, v0, lat;
        ready = 1'b1;
        a0 = ack_rises;
        v0 = valid_cycles;
        send_half(16'h1234, lat);
        checks++;
        if (lat != SYNC_STAGES + 1) begin
            errors++;
            $display("FAIL capture_latency got %0d want %0d", lat, SYNC_STAGES + 1);
        end
        send_half(16'hABCD, lat);
        tick(3);
        checks++;
        if (ack_rises - a0 != 2 || valid_cycles - v0 != 1) begin
            errors++;
            $display("FAIL basic_pulses got acks=%0d valid_cycles=%0d want 2 1", ack_rises - a0, valid_cycles - v0);
        end
        checks++;
        if (last_pop !== 32'hABCD1234 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_word got %h busy=%b want abcd1234 busy=0", last_pop, busy);
        end
    endtask

    task automatic test_stall_full;
        logic [15:0] h[8];
        int lat, n;
        for (int unsigned i = 0; i < 8; i++) h[i] = 16'($urandom);
        ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) send_half(h[i], lat);
        checks++;
        if (valid !== 1'b1 || busy !== 1'b1 || rdata !== {h[1], h[0]}) begin
            errors++;
            $display("FAIL full_state got valid=%b busy=%b rdata=%h want 1 1 %h", valid, busy, rdata, {h[1], h[0]});
        end
        bus_data = h[5];
        stb = 1'b1;
        tick(20);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_ack got ack=%b busy=%b want 0 1", ack, busy);
        end
        // one-cycle ready pulse: pop and push land on the same edge
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        checks++;
        if (ack !== 1'b1 || valid !== 1'b1 || rdata !== {h[3], h[2]}) begin
            errors++;
            $display("FAIL push_pop_full got ack=%b valid=%b rdata=%h want 1 1 %h", ack, valid, rdata, {h[3], h[2]});
        end
        stb = 1'b0;
        n = 0;
        while (ack !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        tick(1);
        send_half(h[6], lat);
        bus_data = h[7];
        stb = 1'b1;
        tick(20);
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL count_stays_full got ack=%b want 0", ack);
        end
        ready = 1'b1;
        n = 0;
        while (ack !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        stb = 1'b0;
        n = 0;
        while (ack !== 1'b0 && n < 50) begin
            tick(1);
            n++;
        end
        drain(50);
        checks++;
        if (last_pop !== {h[7], h[6]}) begin
            errors++;
            $display("FAIL stall_order got %h want %h", last_pop, {h[7], h[6]});
        end
    endtask

    task automatic test_flush;
        int lat;
        ready = 1'b0;
        send_half(16'h1111, lat);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_ptr got busy=%b want 0", busy);
        end
        send_half(16'h5555, lat);
        send_half(16'h6666, lat);
        checks++;
        if (valid !== 1'b1 || rdata !== 32'h66665555) begin
            errors++;
            $display("FAIL flush_word got valid=%b rdata=%h want 1 66665555", valid, rdata);
        end
        send_half(16'h0101, lat);
        send_half(16'h0202, lat);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(1);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_full got valid=%b busy=%b want 0 0", valid, busy);
        end
    endtask

    task automatic test_stale_reset;
        int n = 0;
        int lat;
        ready = 1'b1;
        bus_data = 16'h7777;
        stb = 1'b1;
        while (ack !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_hs got ack=%b valid=%b busy=%b rdata=%h want 0 0 0 0", ack, valid, busy, rdata);
        end
        tick(2);
        rst_n = 1'b1;
        tick(20);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_stb got ack=%b busy=%b want 0 0", ack, busy);
        end
        stb = 1'b0;
        tick(5);
        send_half(16'h2222, lat);
        send_half(16'h3333, lat);
        tick(3);
        checks++;
        if (last_pop !== 32'h33332222) begin
            errors++;
            $display("FAIL post_reset_word got %h want 33332222", last_pop);
        end
    endtask

    task automatic test_random;
        int lat;
        rand_ready = 1'b1;
        for (int unsigned i = 0; i < 40; i++) send_half(16'($urandom), lat);
        rand_ready = 1'b0;
        drain(50);
        ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        oe18_tie = 1'b1;
        bus_data = '0;
        stb      = 1'b0;
        ready    = 1'b0;
        flush    = 1'b0;
        test_reset();
        test_basic();
        test_stall_full();
        test_flush();
        test_stale_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
